// File: rtl/wb_sub_pkg.sv
// Shared types and defaults for the Wishbone classic subordinate.
// The FSM state encoding, the timer width and the read-lane mask helper live here.
package wb_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } wb_sub_state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hBAD0_BAD0;
    localparam int unsigned TIMER_W          = 8;

    // A lane with its select bit low reads back as 8'h00.
    function automatic logic [31:0] byte_mask(input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] masked;
        masked = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) begin
                masked[8*i +: 8] = data[8*i +: 8];
            end
        end
        return masked;
    endfunction

endpackage

// File: rtl/wb_sub_timer.sv
// Transaction timeout counter for the Wishbone subordinate.
// It is loaded with 1 on the strobe cycle and then counts up; expired while count == TIMEOUT.
module wb_sub_timer
    import wb_sub_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= TIMER_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == TIMER_W'(TIMEOUT));

endmodule

// File: rtl/wishbone_subordinate.sv
// Wishbone classic subordinate: one-request-at-a-time register handshake toward a user design,
// with byte-masked read data, a single-cycle ACK and a timeout so the bus can never hang.
module wishbone_subordinate
    import wb_sub_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    input  logic [31:0]       ADR_I,
    input  logic [31:0]       DAT_I,
    input  logic [3:0]        SEL_I,
    output logic              ACK_O,
    output logic [31:0]       DAT_O,
    output logic              USR_WRITE_O,
    output logic              USR_READ_O,
    output logic [ADDR_W-1:0] USR_ADR_O,
    output logic [31:0]       USR_DAT_O,
    output logic [3:0]        USR_SEL_O,
    input  logic [31:0]       USR_DAT_I,
    input  logic              USR_DONE_I,
    output logic              TO_O
);

    wb_sub_state_t     r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic              r_ack;
    logic [31:0]       r_dat_o;
    logic              r_to;
    logic              r_usr_write;
    logic              r_usr_read;

    logic w_req;
    logic w_in_win;
    logic w_busy;
    logic w_tmr_load;
    logic w_tmr_inc;
    logic w_tmr_clear;
    logic w_expired;
    logic w_unused_adr;

    assign w_req        = CYC_I & STB_I;
    assign w_in_win     = (ADR_I[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_busy       = (r_state == REQ) || (r_state == WAIT);
    assign w_unused_adr = ^ADR_I[1:0];

    // Count 1 lands in the REQ cycle, so count == TIMEOUT is seen in cycle TIMEOUT of the request.
    assign w_tmr_load  = (r_state == IDLE) && w_req && w_in_win;
    assign w_tmr_inc   = w_busy && CYC_I && !USR_DONE_I;
    assign w_tmr_clear = !w_tmr_load && !w_tmr_inc;

    wb_sub_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (CLK),
        .i_rst_n   (nRST),
        .i_load    (w_tmr_load),
        .i_inc     (w_tmr_inc),
        .i_clear   (w_tmr_clear),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_ack       <= 1'b0;
            r_dat_o     <= '0;
            r_to        <= 1'b0;
            r_usr_write <= 1'b0;
            r_usr_read  <= 1'b0;
        end else begin
            // Pulse-type outputs fall back to 0 unless a transition below raises them.
            r_ack       <= 1'b0;
            r_dat_o     <= '0;
            r_to        <= 1'b0;
            r_usr_write <= 1'b0;
            r_usr_read  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_in_win) begin
                            r_we        <= WE_I;
                            r_adr       <= ADR_I[ADDR_W+1:2];
                            r_dat       <= DAT_I;
                            r_sel       <= SEL_I;
                            r_usr_write <= WE_I;
                            r_usr_read  <= ~WE_I;
                            r_state     <= REQ;
                        end else begin
                            r_ack   <= 1'b1;
                            r_dat_o <= WE_I ? '0 : ERR_DATA;
                            r_state <= ACK;
                        end
                    end
                end

                REQ, WAIT: begin
                    if (!CYC_I) begin
                        r_state <= IDLE;
                    end else if (USR_DONE_I) begin
                        r_ack   <= 1'b1;
                        r_dat_o <= r_we ? '0 : byte_mask(USR_DAT_I, r_sel);
                        r_state <= ACK;
                    end else if ((r_state == WAIT) && w_expired) begin
                        r_ack   <= 1'b1;
                        r_to    <= 1'b1;
                        r_dat_o <= r_we ? '0 : ERR_DATA;
                        r_state <= ACK;
                    end else begin
                        r_state <= WAIT;
                    end
                end

                ACK: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ACK_O       = r_ack;
    assign DAT_O       = r_dat_o;
    assign TO_O        = r_to;
    assign USR_WRITE_O = r_usr_write;
    assign USR_READ_O  = r_usr_read;
    assign USR_ADR_O   = r_adr;
    assign USR_DAT_O   = r_dat;
    assign USR_SEL_O   = r_sel;

endmodule

// File: tb/tb_wishbone_subordinate.sv
// Directed, table-driven bench for wishbone_subordinate (TIMEOUT = 16, 1 KB window at 0x3000_0000).
// Cycle n is the clock period that ends at edge n; the request is sampled at edge 0.
module tb_wishbone_subordinate;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CYC_I = 1'b0;
    logic        STB_I = 1'b0;
    logic        WE_I = 1'b0;
    logic [31:0] ADR_I = '0;
    logic [31:0] DAT_I = '0;
    logic [3:0]  SEL_I = '0;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        USR_WRITE_O;
    logic        USR_READ_O;
    logic [7:0]  USR_ADR_O;
    logic [31:0] USR_DAT_O;
    logic [3:0]  USR_SEL_O;
    logic [31:0] USR_DAT_I = '0;
    logic        USR_DONE_I = 1'b0;
    logic        TO_O;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    wishbone_subordinate #(
        .BASE_ADDR (32'h3000_0000),
        .ADDR_W    (8),
        .TIMEOUT   (16),
        .ERR_DATA  (32'hBAD0_BAD0)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .CYC_I       (CYC_I),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ADR_I       (ADR_I),
        .DAT_I       (DAT_I),
        .SEL_I       (SEL_I),
        .ACK_O       (ACK_O),
        .DAT_O       (DAT_O),
        .USR_WRITE_O (USR_WRITE_O),
        .USR_READ_O  (USR_READ_O),
        .USR_ADR_O   (USR_ADR_O),
        .USR_DAT_O   (USR_DAT_O),
        .USR_SEL_O   (USR_SEL_O),
        .USR_DAT_I   (USR_DAT_I),
        .USR_DONE_I  (USR_DONE_I),
        .TO_O        (TO_O)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] udat_in;
        int          k;
        int          e_ack;
        logic [31:0] e_dat;
        logic        e_to;
        int          e_wr;
        int          e_rd;
        logic [7:0]  e_uadr;
        logic [31:0] e_udat;
        logic [3:0]  e_usel;
    } vec_t;

    typedef struct {
        int          ack;
        logic [31:0] dat;
        logic        to;
        int          wr;
        int          rd;
        logic [7:0]  uadr;
        logic [31:0] udat;
        logic [3:0]  usel;
        int          glitch;
    } res_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ack"},   32'(ACK_O), 32'h0);
        check({tag, ".dat_o"}, DAT_O, 32'h0);
        check({tag, ".to"},    32'(TO_O), 32'h0);
        check({tag, ".wr"},    32'(USR_WRITE_O), 32'h0);
        check({tag, ".rd"},    32'(USR_READ_O), 32'h0);
        check({tag, ".uadr"},  32'(USR_ADR_O), 32'h0);
        check({tag, ".udat"},  USR_DAT_O, 32'h0);
        check({tag, ".usel"},  32'(USR_SEL_O), 32'h0);
    endtask

    // Called just after a rising edge; returns just after the edge that samples the ACK.
    // k < 0 means the design never answers; otherwise done is high in cycle k+1.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] udat_in, input int k,
                           output res_t r);
        r.ack = -1; r.dat = '0; r.to = 1'b0; r.wr = 0; r.rd = 0;
        r.uadr = '0; r.udat = '0; r.usel = '0; r.glitch = 0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
        USR_DAT_I = udat_in; USR_DONE_I = 1'b0;
        @(posedge CLK);
        for (int c = 1; c <= 40; c++) begin
            #1;
            USR_DONE_I = (k >= 0) && (c == k + 1);
            @(negedge CLK);
            if (USR_WRITE_O) r.wr++;
            if (USR_READ_O) r.rd++;
            if (ACK_O) begin
                r.ack = c; r.dat = DAT_O; r.to = TO_O;
                r.uadr = USR_ADR_O; r.udat = USR_DAT_O; r.usel = USR_SEL_O;
                break;
            end
            if (DAT_O != 32'h0 || TO_O) r.glitch++;
            @(posedge CLK);
        end
        @(posedge CLK);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; USR_DONE_I = 1'b0;
    endtask

    task automatic check_res(input vec_t v, input res_t r);
        check({v.name, ".ack_cycle"}, 32'(r.ack), 32'(v.e_ack));
        check({v.name, ".dat_o"},     r.dat, v.e_dat);
        check({v.name, ".to"},        32'(r.to), 32'(v.e_to));
        check({v.name, ".wr_pulses"}, 32'(r.wr), 32'(v.e_wr));
        check({v.name, ".rd_pulses"}, 32'(r.rd), 32'(v.e_rd));
        check({v.name, ".usr_adr"},   32'(r.uadr), 32'(v.e_uadr));
        check({v.name, ".usr_dat"},   r.udat, v.e_udat);
        check({v.name, ".usr_sel"},   32'(r.usel), 32'(v.e_usel));
        check({v.name, ".glitch"},    32'(r.glitch), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   ack_seen;
        int   to_seen;
        int   stb_seen;

        //        name         we    adr            dat            sel   udat_in        k   ack e_dat          to  wr rd uadr   udat           usel
        vecs[0] = '{"wr_basic",  1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF, 32'h0000_0000, 3,  5, 32'h0000_0000, 1'b0, 1, 0, 8'h04, 32'h1234_5678, 4'hF};
        vecs[1] = '{"rd_mask",   1'b0, 32'h3000_0000, 32'h0000_0000, 4'h4, 32'h12BB_56AA, 0,  2, 32'h00BB_0000, 1'b0, 0, 1, 8'h00, 32'h0000_0000, 4'h4};
        vecs[2] = '{"rd_tmo",    1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF, 32'h1111_1111, -1, 17, 32'hBAD0_BAD0, 1'b1, 0, 1, 8'h08, 32'h0000_0000, 4'hF};
        vecs[3] = '{"rd_after",  1'b0, 32'h3000_03FC, 32'h0000_0000, 4'h9, 32'hA1B2_C3D4, 1,  3, 32'hA100_00D4, 1'b0, 0, 1, 8'hFF, 32'h0000_0000, 4'h9};
        vecs[4] = '{"rd_oow",    1'b0, 32'h3100_0000, 32'hDEAD_BEEF, 4'hF, 32'h7777_7777, 0,  1, 32'hBAD0_BAD0, 1'b0, 0, 0, 8'hFF, 32'h0000_0000, 4'h9};
        vecs[5] = '{"wr_oow",    1'b1, 32'h2FFF_FFFC, 32'hCAFE_F00D, 4'h3, 32'h0000_0000, -1, 1, 32'h0000_0000, 1'b0, 0, 0, 8'hFF, 32'h0000_0000, 4'h9};
        vecs[6] = '{"rd_lastcyc",1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 32'h55AA_55AA, 15, 17, 32'h55AA_55AA, 1'b0, 0, 1, 8'h01, 32'h0000_0000, 4'hF};
        vecs[7] = '{"wr_tmo",    1'b1, 32'h3000_0008, 32'h0F0F_0F0F, 4'h5, 32'h0000_0000, -1, 17, 32'h0000_0000, 1'b1, 1, 0, 8'h02, 32'h0F0F_0F0F, 4'h5};
        vecs[8] = '{"rd_sel0",   1'b0, 32'h3000_00C0, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 2,  4, 32'h0000_0000, 1'b0, 0, 1, 8'h30, 32'h0000_0000, 4'h0};
        vecs[9] = '{"rd_winend", 1'b0, 32'h3000_0400, 32'h0000_0000, 4'hF, 32'h0000_0000, -1, 1, 32'hBAD0_BAD0, 1'b0, 0, 0, 8'h30, 32'h0000_0000, 4'h0};

        #3;
        check_idle_outputs("reset");
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].udat_in, vecs[i].k, r);
            check_res(vecs[i], r);
            @(posedge CLK);
            #1;
        end

        // Abort: CYC_I drops while waiting, then a late done arrives in IDLE.
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h3000_0014; SEL_I = 4'hF;
        USR_DAT_I = 32'h1234_5678;
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0;
        ack_seen = 0; to_seen = 0; stb_seen = 0;
        for (int c = 4; c <= 25; c++) begin
            @(negedge CLK);
            if (ACK_O) ack_seen++;
            if (TO_O) to_seen++;
            if (USR_READ_O || USR_WRITE_O) stb_seen++;
            @(posedge CLK);
            #1;
            USR_DONE_I = (c == 4);
        end
        USR_DONE_I = 1'b0;
        check("abort.ack_seen", 32'(ack_seen), 32'h0);
        check("abort.to_seen",  32'(to_seen), 32'h0);
        check("abort.strobes",  32'(stb_seen), 32'h0);
        run_txn(1'b1, 32'h3000_0018, 32'h1357_9BDF, 4'hF, 32'h0, 0, r);
        check_res('{"abort_next", 1'b1, 32'h3000_0018, 32'h1357_9BDF, 4'hF, 32'h0, 0, 2, 32'h0, 1'b0, 1, 0, 8'h06, 32'h1357_9BDF, 4'hF}, r);
        @(posedge CLK);
        #1;

        // Reset while in WAIT drops everything at once.
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h3000_0010; DAT_I = 32'h89AB_CDEF;
        SEL_I = 4'hF; USR_DAT_I = 32'h0;
        @(posedge CLK);
        repeat (2) @(posedge CLK);
        #3;
        check("rst_pre.usr_adr", 32'(USR_ADR_O), 32'h04);
        nRST = 1'b0;
        #1;
        check_idle_outputs("rst_wait");
        CYC_I = 1'b0; STB_I = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h0102_0304, 0, r);
        check_res('{"b2b_read", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h0102_0304, 0, 2, 32'h0102_0304, 1'b0, 0, 1, 8'h08, 32'h0, 4'hF}, r);
        run_txn(1'b1, 32'h3000_0024, 32'hA5A5_5A5A, 4'hC, 32'h0, 0, r);
        check_res('{"b2b_write", 1'b1, 32'h3000_0024, 32'hA5A5_5A5A, 4'hC, 32'h0, 0, 2, 32'h0, 1'b0, 1, 0, 8'h09, 32'hA5A5_5A5A, 4'hC}, r);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
